// File: rtl/recip_pkg.sv
// recip_pkg: shared types and constants for the reciprocal engine.
//   state_e        engine FSM states (3-bit encoding)
//   div_step_t     partial remainder / quotient pair for one divide step
//   div_step()     one restoring-division iteration
package recip_pkg;

  localparam int unsigned DATA_W           = 16;
  localparam int unsigned REM_W            = 17;
  localparam int unsigned CNT_W            = 5;
  localparam int unsigned DEF_AW           = 8;
  localparam int unsigned DEF_OPERAND_ADDR = 8;
  localparam int unsigned DEF_RESULT_ADDR  = 10;

  localparam logic [DATA_W-1:0] RECIP_DIVIDEND = 16'h8000;
  localparam logic [DATA_W-1:0] RECIP_SAT      = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_HI = 3'd1,
    S_RD_LO = 3'd2,
    S_DIV   = 3'd3,
    S_WR_HI = 3'd4,
    S_WR_LO = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  typedef struct packed {
    logic [REM_W-1:0]  rem;
    logic [DATA_W-1:0] quo;
  } div_step_t;

  // Shift the next dividend bit into the remainder, subtract if it fits.
  // The remainder stays below the divisor, so dropping its MSB on the shift loses nothing.
  function automatic div_step_t div_step(input logic [REM_W-1:0]  rem,
                                         input logic [DATA_W-1:0] quo,
                                         input logic [DATA_W-1:0] divisor);
    div_step_t   w_res;
    logic [REM_W-1:0] w_shift;
    logic [REM_W-1:0] w_dvs;
    w_shift = REM_W'({rem, quo[DATA_W-1]});
    w_dvs   = {1'b0, divisor};
    if (w_shift >= w_dvs) begin
      w_res.rem = w_shift - w_dvs;
      w_res.quo = {quo[DATA_W-2:0], 1'b1};
    end else begin
      w_res.rem = w_shift;
      w_res.quo = {quo[DATA_W-2:0], 1'b0};
    end
    return w_res;
  endfunction

endpackage

// File: rtl/recip_divider.sv
// recip_divider: sequential 16-bit restoring divider, one quotient bit per cycle.
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_load          start a division; the first bit is resolved on the load edge
//   i_dividend      dividend, sampled on load
//   i_divisor       divisor, sampled on load (must be nonzero)
//   o_quotient      quotient, final while o_done is high
//   o_done          one-cycle pulse once all 16 bits are resolved
module recip_divider
  import recip_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quotient,
  output logic              o_done
);

  logic [REM_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_div;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;

  div_step_t w_first;
  div_step_t w_step;

  // The load edge performs iteration 1 from the live divisor so the engine
  // sees done after the 15 remaining iterations.
  assign w_first = div_step('0, i_dividend, i_divisor);
  assign w_step  = div_step(r_rem, r_quo, r_div);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_load) begin
      r_rem  <= w_first.rem;
      r_quo  <= w_first.quo;
      r_div  <= i_divisor;
      r_cnt  <= CNT_W'(DATA_W - 1);
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      r_rem  <= w_step.rem;
      r_quo  <= w_step.quo;
      r_cnt  <= r_cnt - CNT_W'(1);
      r_done <= (r_cnt == CNT_W'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_quotient = r_quo;
  assign o_done     = r_done;

endmodule

// File: rtl/recip_engine.sv
// recip_engine: Start/Ack launched engine that reads a 16-bit divisor from
// memory, computes floor(32768/d) (0xFFFF for d=0) and writes it back.
//   Clk, Reset   clock, synchronous active-high reset
//   Start        launch level; a 1->0 transition seen in IDLE starts a run
//   Ack          run complete, held until Start is seen high in DONE
//   MemAddr      data-memory byte address
//   MemRdData    asynchronous read data for MemAddr
//   MemWrData    write data
//   MemWrEn      write strobe, memory writes on the rising edge
module recip_engine
  import recip_pkg::*;
#(
  parameter int unsigned    AW           = DEF_AW,
  parameter logic [AW-1:0]  OPERAND_ADDR = AW'(DEF_OPERAND_ADDR),
  parameter logic [AW-1:0]  RESULT_ADDR  = AW'(DEF_RESULT_ADDR)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic          Ack,
  output logic [AW-1:0] MemAddr,
  input  logic [7:0]    MemRdData,
  output logic [7:0]    MemWrData,
  output logic          MemWrEn
);

  state_e        r_state;
  logic          r_start_q;
  logic [7:0]    r_div_hi;
  logic [7:0]    r_res_lo;
  logic          r_ack;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wr_data;
  logic          r_wr_en;

  logic [DATA_W-1:0] w_divisor;
  logic              w_load;
  logic [DATA_W-1:0] w_quotient;
  logic              w_div_done;

  // Low byte is taken straight from the read port in RD_LO; the divider
  // latches the full divisor on its load edge.
  assign w_divisor = {r_div_hi, MemRdData};
  assign w_load    = (r_state == S_RD_LO) && (w_divisor != '0);

  recip_divider u_divider (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_load     (w_load),
    .i_dividend (RECIP_DIVIDEND),
    .i_divisor  (w_divisor),
    .o_quotient (w_quotient),
    .o_done     (w_div_done)
  );

  // Control FSM; memory port and Ack are registered alongside the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_div_hi  <= '0;
      r_res_lo  <= '0;
      r_ack     <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      r_start_q <= Start;
      case (r_state)
        S_IDLE: begin
          if (r_start_q && !Start) begin
            r_addr  <= OPERAND_ADDR;
            r_state <= S_RD_HI;
          end
        end
        S_RD_HI: begin
          r_div_hi <= MemRdData;
          r_addr   <= OPERAND_ADDR + AW'(1);
          r_state  <= S_RD_LO;
        end
        S_RD_LO: begin
          if (w_divisor == '0) begin
            r_res_lo  <= RECIP_SAT[7:0];
            r_addr    <= RESULT_ADDR;
            r_wr_data <= RECIP_SAT[15:8];
            r_wr_en   <= 1'b1;
            r_state   <= S_WR_HI;
          end else begin
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            r_res_lo  <= w_quotient[7:0];
            r_addr    <= RESULT_ADDR;
            r_wr_data <= w_quotient[15:8];
            r_wr_en   <= 1'b1;
            r_state   <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          r_addr    <= RESULT_ADDR + AW'(1);
          r_wr_data <= r_res_lo;
          r_wr_en   <= 1'b1;
          r_state   <= S_WR_LO;
        end
        S_WR_LO: begin
          r_wr_en <= 1'b0;
          r_ack   <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (Start) begin
            r_ack   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_wr_en <= 1'b0;
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Ack       = r_ack;
  assign MemAddr   = r_addr;
  assign MemWrData = r_wr_data;
  assign MemWrEn   = r_wr_en;

endmodule

// File: tb/tb_recip_engine.sv
// tb_recip_engine: scoreboard bench for recip_engine with a byte memory model.
module tb_recip_engine;

  localparam int unsigned AW       = 8;
  localparam int unsigned RES_ADDR = 10;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic          Ack;
  logic [AW-1:0] MemAddr;
  logic [7:0]    MemRdData;
  logic [7:0]    MemWrData;
  logic          MemWrEn;

  logic [7:0]    mem [256];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    int unsigned ack_cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic ack_q = 1'b0;

  recip_engine dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .MemAddr   (MemAddr),
    .MemRdData (MemRdData),
    .MemWrData (MemWrData),
    .MemWrEn   (MemWrEn)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Memory: DUT writes take priority over bench preloads.
  assign MemRdData = mem[MemAddr];
  always @(posedge Clk) begin
    if (MemWrEn) mem[MemAddr] <= MemWrData;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on each Ack rise, pop the expected result and compare.
  always @(negedge Clk) begin
    if (!Reset && MemWrEn)
      chk("wr_addr_range", 32'((MemAddr == AW'(RES_ADDR)) || (MemAddr == AW'(RES_ADDR + 1))), 32'd1);
    if (Ack && !ack_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd0, 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("result_hi", 32'(mem[RES_ADDR]), 32'(mon_e.hi));
        chk("result_lo", 32'(mem[RES_ADDR + 1]), 32'(mon_e.lo));
        chk("ack_cycle", cyc, mon_e.ack_cyc);
      end
    end
    ack_q = Ack;
  end

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge Clk);
    pl_en   = 1'b0;
  endtask

  // Leave DONE (if there), launch, optionally toggle Start mid-DIV, wait for Ack.
  task automatic run(input logic [15:0] d, input logic [7:0] hi, input logic [7:0] lo,
                     input bit toggle);
    int unsigned e0;
    bit got;
    poke(AW'(8), d[15:8]);
    poke(AW'(9), d[7:0]);
    if (!Start) begin
      chk("ack_hold", 32'(Ack), 32'd1);
      Start = 1'b1;
      @(negedge Clk);
      chk("ack_drop", 32'(Ack), 32'd0);
    end
    e0 = cyc + 1;
    sb.push_back('{hi, lo, e0 + ((d == 16'h0000) ? 32'd4 : 32'd20)});
    Start = 1'b0;
    if (toggle) begin
      repeat (6) @(negedge Clk);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit saw_wr;
    bit saw_ack;
    Reset   = 1'b1;
    Start   = 1'b1;
    pl_en   = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    repeat (3) @(negedge Clk);
    chk("reset_ack", 32'(Ack), 32'd0);
    chk("reset_wren", 32'(MemWrEn), 32'd0);
    chk("reset_addr", 32'(MemAddr), 32'd0);
    chk("reset_wdata", 32'(MemWrData), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    run(16'h0003, 8'h2A, 8'hAA, 1'b0);
    run(16'h0004, 8'h20, 8'h00, 1'b0);
    run(16'h0001, 8'h80, 8'h00, 1'b0);
    run(16'h8000, 8'h00, 8'h01, 1'b0);
    run(16'h8001, 8'h00, 8'h00, 1'b0);
    run(16'hFFFF, 8'h00, 8'h00, 1'b0);
    run(16'h0000, 8'hFF, 8'hFF, 1'b0);

    // Abort: reset during the 8th DIV cycle must leave the preset bytes intact.
    poke(AW'(RES_ADDR), 8'h55);
    poke(AW'(RES_ADDR + 1), 8'h55);
    poke(AW'(8), 8'h00);
    poke(AW'(9), 8'h03);
    chk("ack_hold", 32'(Ack), 32'd1);
    Start = 1'b1;
    @(negedge Clk);
    chk("ack_drop", 32'(Ack), 32'd0);
    saw_wr  = 1'b0;
    saw_ack = 1'b0;
    Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      saw_wr  |= MemWrEn;
      saw_ack |= Ack;
    end
    Reset = 1'b1;
    Start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      saw_wr  |= MemWrEn;
      saw_ack |= Ack;
    end
    Reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      saw_wr  |= MemWrEn;
      saw_ack |= Ack;
    end
    chk("abort_wren", 32'(saw_wr), 32'd0);
    chk("abort_ack", 32'(saw_ack), 32'd0);
    chk("abort_hi", 32'(mem[RES_ADDR]), 32'h55);
    chk("abort_lo", 32'(mem[RES_ADDR + 1]), 32'h55);

    run(16'h0003, 8'h2A, 8'hAA, 1'b0);
    run(16'h0007, 8'h12, 8'h49, 1'b1);
    run(16'h0005, 8'h19, 8'h99, 1'b0);

    chk("ack_hold", 32'(Ack), 32'd1);
    Start = 1'b1;
    @(negedge Clk);
    chk("ack_drop", 32'(Ack), 32'd0);
    repeat (3) @(negedge Clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
